// File: rtl/edge_det_pkg.sv
// Shared types and constants for the multi-channel edge detector.
// Holds the per-channel mode encoding and a width helper for counters.
package edge_det_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int edge_clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, debounce filter, delayed level
// and registered rise/fall/mode-selected edge pulses.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  data_in,
    input  mode_t mode,
    output logic  level,
    output logic  rise_pulse,
    output logic  fall_pulse,
    output logic  edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign level = sync;
        end else begin : g_debounce
            localparam int             CW       = edge_clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          level_q;

            // Any sample agreeing with the filtered level restarts the run.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt     <= '0;
                    level_q <= 1'b0;
                end else if (sync == level_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level_q <= sync;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign level = level_q;
        end
    endgenerate

    logic level_d;
    logic rise_n;
    logic fall_n;
    logic sel_rise;
    logic sel_fall;

    always_comb begin
        rise_n   = level & ~level_d;
        fall_n   = ~level & level_d;
        sel_rise = (mode == MODE_RISE) || (mode == MODE_BOTH);
        sel_fall = (mode == MODE_FALL) || (mode == MODE_BOTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            level_d    <= level;
            rise_pulse <= rise_n;
            fall_pulse <= fall_n;
            edge_pulse <= (rise_n & sel_rise) | (fall_n & sel_fall);
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector with sticky W1C status and a masked registered irq.
// Defining EDGE_DET_COUNT_EN adds saturating per-channel edge counters.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     data_in,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     irq_mask,
    input  logic [NUM_CH-1:0]     status_clr,
    output logic [NUM_CH-1:0]     level,
    output logic [NUM_CH-1:0]     rise_pulse,
    output logic [NUM_CH-1:0]     fall_pulse,
    output logic [NUM_CH-1:0]     edge_pulse,
    output logic [NUM_CH-1:0]     status,
    output logic                  irq
`ifdef EDGE_DET_COUNT_EN
    ,
    output logic [CNT_W*NUM_CH-1:0] edge_count
`endif
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            edge_det_chan #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk        (clk),
                .reset      (reset),
                .data_in    (data_in[i]),
                .mode       (mode_t'(mode[2*i +: 2])),
                .level      (level[i]),
                .rise_pulse (rise_pulse[i]),
                .fall_pulse (fall_pulse[i]),
                .edge_pulse (edge_pulse[i])
            );
        end
    endgenerate

    // A new edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            status <= edge_pulse | (status & ~status_clr);
            irq    <= |(status & irq_mask);
        end
    end

`ifdef EDGE_DET_COUNT_EN
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_count
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt <= '0;
                end else if (status_clr[i]) begin
                    cnt <= '0;
                end else if (edge_pulse[i] && (cnt != {CNT_W{1'b1}})) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign edge_count[CNT_W*i +: CNT_W] = cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios followed by random inputs,
// every cycle compared against a window-based reference model.
module tb_multi_edge_detector;

    localparam int NUM_CH = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DEB = 3;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NUM_CH-1:0] data_in = '0;
    logic [2*NUM_CH-1:0] mode = '0;
    logic [NUM_CH-1:0] irq_mask = '0;
    logic [NUM_CH-1:0] status_clr = '0;
    logic [NUM_CH-1:0] level, rise_pulse, fall_pulse, edge_pulse, status;
    logic irq;
`ifdef EDGE_DET_COUNT_EN
    logic [CNT_W*NUM_CH-1:0] edge_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .mode(mode),
        .irq_mask(irq_mask), .status_clr(status_clr), .level(level),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .edge_pulse(edge_pulse),
        .status(status), .irq(irq)
`ifdef EDGE_DET_COUNT_EN
        , .edge_count(edge_count)
`endif
    );

    // Reference model: sync is data_in from SYNC_STAGES edges back (0 before that);
    // level flips once D consecutive post-change samples all disagree with it.
    bit sq[NUM_CH][$];
    bit dq[NUM_CH][$];
    bit [NUM_CH-1:0] m_level = '0, m_level_d = '0, m_rise = '0, m_fall = '0, m_edge = '0, m_status = '0;
    bit m_irq = 1'b0;
    bit [CNT_W-1:0] m_cnt[NUM_CH];

    function automatic bit sync_of(input int c);
        return (sq[c].size() < SYNC_STAGES) ? 1'b0 : sq[c][0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sq[c].delete();
                dq[c].delete();
                m_cnt[c] = '0;
            end
            m_level = '0; m_level_d = '0; m_rise = '0; m_fall = '0;
            m_edge = '0; m_status = '0; m_irq = 1'b0;
        end else begin
            bit [NUM_CH-1:0] old_edge, old_status;
            old_edge = m_edge;
            old_status = m_status;
            m_irq = |(old_status & irq_mask);
            m_status = old_edge | (old_status & ~status_clr);
            for (int c = 0; c < NUM_CH; c++) begin
                bit pre_lvl, pre_lvl_d, pre_sync, r, f;
                if (status_clr[c]) m_cnt[c] = '0;
                else if (old_edge[c] && m_cnt[c] != {CNT_W{1'b1}}) m_cnt[c] = m_cnt[c] + 1'b1;
                pre_lvl = m_level[c];
                pre_lvl_d = m_level_d[c];
                r = pre_lvl & ~pre_lvl_d;
                f = ~pre_lvl & pre_lvl_d;
                m_rise[c] = r;
                m_fall[c] = f;
                m_edge[c] = (r & mode[2*c]) | (f & mode[2*c+1]);
                m_level_d[c] = pre_lvl;
                pre_sync = sync_of(c);
                sq[c].push_back(data_in[c]);
                if (sq[c].size() > SYNC_STAGES) void'(sq[c].pop_front());
                if (DEB == 0) begin
                    m_level[c] = sync_of(c);
                end else begin
                    if (pre_sync != pre_lvl) dq[c].push_back(pre_sync);
                    else dq[c].delete();
                    if (dq[c].size() >= DEB) begin
                        m_level[c] = pre_sync;
                        dq[c].delete();
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("level", 64'(level), 64'(m_level));
        chk("rise_pulse", 64'(rise_pulse), 64'(m_rise));
        chk("fall_pulse", 64'(fall_pulse), 64'(m_fall));
        chk("edge_pulse", 64'(edge_pulse), 64'(m_edge));
        chk("status", 64'(status), 64'(m_status));
        chk("irq", 64'(irq), 64'(m_irq));
`ifdef EDGE_DET_COUNT_EN
        for (int c = 0; c < NUM_CH; c++)
            chk("edge_count", 64'(edge_count[CNT_W*c +: CNT_W]), 64'(m_cnt[c]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        check_model();
    endtask

    task automatic wait_edge(input int c, input int max_cyc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < max_cyc && !found; k++) begin
            tick();
            if (edge_pulse[c]) found = 1'b1;
        end
        n_cmp++;
        assert (found) else begin
            n_fail++;
            $error("FAIL wait_edge ch%0d observed=timeout expected=pulse", c);
        end
    endtask

    initial begin
        int first_k, n_hi, n_edge, n_fall, glitch_seen;
        int hold[NUM_CH];

        // Reset with all inputs low.
        #50;
        chk("reset_outputs", 64'({level, rise_pulse, fall_pulse, edge_pulse, status, irq}), 64'd0);
        check_model();
        reset = 1'b0;
        n_hi = 0;
        repeat (20) begin
            tick();
            n_hi += $countones({rise_pulse, fall_pulse, edge_pulse});
        end
        chk("idle_no_pulses", 64'(n_hi), 64'd0);

        // ch0 rise mode: pulse exactly 6 cycles after capture, then fall only.
        mode[1:0] = 2'b01;
        irq_mask = 4'b0001;
        data_in[0] = 1'b1;
        first_k = 0; n_hi = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (rise_pulse[0] && edge_pulse[0]) begin
                n_hi++;
                if (first_k == 0) first_k = k;
            end
        end
        chk("ch0_rise_latency", 64'(first_k), 64'd6);
        chk("ch0_rise_width", 64'(n_hi), 64'd1);
        chk("ch0_status", 64'(status[0]), 64'd1);
        chk("ch0_irq", 64'(irq), 64'd1);
        data_in[0] = 1'b0;
        n_fall = 0; n_edge = 0;
        repeat (12) begin
            tick();
            n_fall += int'(fall_pulse[0]);
            n_edge += int'(edge_pulse[0]);
        end
        chk("ch0_fall_count", 64'(n_fall), 64'd1);
        chk("ch0_fall_no_edge", 64'(n_edge), 64'd0);

        // ch1 both mode: 2-cycle glitch rejected, 3-cycle pulse accepted.
        mode[3:2] = 2'b11;
        data_in[1] = 1'b1;
        tick(); tick();
        data_in[1] = 1'b0;
        glitch_seen = 0;
        repeat (12) begin
            tick();
            glitch_seen += int'(level[1]) + int'(rise_pulse[1]) + int'(fall_pulse[1]) + int'(edge_pulse[1]);
        end
        chk("ch1_glitch_rejected", 64'(glitch_seen), 64'd0);
        data_in[1] = 1'b1;
        tick(); tick(); tick();
        data_in[1] = 1'b0;
        n_edge = 0;
        repeat (20) begin
            tick();
            n_edge += int'(edge_pulse[1]);
        end
        chk("ch1_two_edges", 64'(n_edge), 64'd2);

        // ch2: set beats clear in the same cycle; clear alone drops status, irq follows.
        status_clr = '1;
        tick();
        status_clr = '0;
        irq_mask = 4'b0100;
        mode[5:4] = 2'b01;
        data_in[2] = 1'b1;
        wait_edge(2, 20);
        tick();
        chk("ch2_status_set", 64'(status[2]), 64'd1);
        data_in[2] = 1'b0;
        repeat (10) tick();
        data_in[2] = 1'b1;
        wait_edge(2, 20);
        status_clr[2] = 1'b1;
        tick();
        status_clr[2] = 1'b0;
        chk("ch2_set_wins", 64'(status[2]), 64'd1);
        tick();
        status_clr[2] = 1'b1;
        tick();
        status_clr[2] = 1'b0;
        chk("ch2_cleared", 64'(status[2]), 64'd0);
        chk("ch2_irq_lags", 64'(irq), 64'd1);
        tick();
        chk("ch2_irq_dropped", 64'(irq), 64'd0);

        // ch3: reset mid-debounce, input held high, rise 6 cycles after release.
        mode[7:6] = 2'b01;
        data_in[3] = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("ch3_reset_level", 64'(level[3]), 64'd0);
        check_model();
        tick(); tick();
        chk("ch3_reset_no_pulse", 64'(rise_pulse[3]), 64'd0);
        reset = 1'b0;
        first_k = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (rise_pulse[3] && first_k == 0) first_k = k;
        end
        chk("ch3_rise_after_reset", 64'(first_k), 64'd6);

        // Five rises on ch0 saturate a 2-bit counter; clear returns it to 0.
        for (int n = 0; n < 5; n++) begin
            data_in[0] = 1'b1;
            repeat (8) tick();
            data_in[0] = 1'b0;
            repeat (8) tick();
        end
`ifdef EDGE_DET_COUNT_EN
        chk("ch0_count_sat", 64'(edge_count[CNT_W-1:0]), 64'd3);
`endif
        status_clr[0] = 1'b1;
        tick();
        status_clr[0] = 1'b0;
`ifdef EDGE_DET_COUNT_EN
        chk("ch0_count_clr", 64'(edge_count[CNT_W-1:0]), 64'd0);
`endif
        chk("ch0_status_clr", 64'(status[0]), 64'd0);

        // Randomised inputs, modes, masks and clears with one mid-run reset.
        for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hold[c] == 0) begin
                    data_in[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 7);
                end else begin
                    hold[c]--;
                end
            end
            if (cyc % 50 == 0) begin
                mode = 8'($urandom_range(0, 255));
                irq_mask = 4'($urandom_range(0, 15));
            end
            status_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (cyc == 700) begin
                reset = 1'b1;
                #1;
                check_model();
            end
            if (cyc == 702) reset = 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
